div_addr_fetch: RTL

- Downstream consumer of the divider address counter. Drives the counter's enable, turns each count value into a RAM read, and buffers the returned words.
- Presents the words as a valid/ready stream with phase and last tags.
- Stalls the counter whenever the output buffer cannot absorb another read, so no address is skipped or fetched twice.

---
 rtl/div_addr_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/div_addr_fetch.sv
// Fetch engine for the divider address counter: steps the counter, reads RAM,
// and streams the returned words through a small credit-managed FIFO.
module div_addr_fetch #(
  parameter int unsigned                   RAM_ADDR_WIDTH = 7,
  parameter int unsigned                   DATA_WIDTH     = 16,
  parameter logic [RAM_ADDR_WIDTH+1:0]     LAST_CNT       = 9'd511,
  parameter int unsigned                   FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        syn_reset_n,
  input  logic                        start,
  input  logic [RAM_ADDR_WIDTH+1:0]   cnt_in,
  output logic                        cnt_enable,
  output logic                        ram_rd_en,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_addr,
  input  logic [DATA_WIDTH-1:0]       ram_rdata,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [1:0]                  out_phase,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned SUM_W  = FCNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [1:0]            phase;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_t               state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           infl_phase_q, infl_phase_d;
  logic                 infl_last_q, infl_last_d;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;

  logic                 issue_ok;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 at_last;
  entry_t               head;

  // Credit uses registered occupancy only; a same-cycle pop is not counted.
  assign issue_ok = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
  assign at_last  = (cnt_in == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!syn_reset_n) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PRIME;
      S_PRIME: state_d = S_RUN;
      S_RUN:   if (issue && at_last) state_d = S_DRAIN;
      S_DRAIN: if ((count_q == '0) && !inflight_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    cnt_enable = 1'b0;
    ram_rd_en  = 1'b0;
    ram_addr   = '0;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    if ((state_q == S_RUN) && issue_ok) begin
      issue      = 1'b1;
      cnt_enable = 1'b1;
      ram_rd_en  = 1'b1;
      ram_addr   = cnt_in[RAM_ADDR_WIDTH-1:0];
    end
  end

  // In-flight slot and FIFO bookkeeping.
  always_comb begin
    push         = inflight_q;
    pop          = (count_q != '0) && out_ready;
    inflight_d   = issue;
    infl_phase_d = issue ? cnt_in[RAM_ADDR_WIDTH+1:RAM_ADDR_WIDTH] : infl_phase_q;
    infl_last_d  = issue ? at_last : infl_last_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{last: infl_last_q, phase: infl_phase_q, data: ram_rdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      inflight_q   <= 1'b0;
      infl_phase_q <= '0;
      infl_last_q  <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      inflight_q   <= inflight_d;
      infl_phase_q <= infl_phase_d;
      infl_last_q  <= infl_last_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head.data;
  assign out_phase = head.phase;
  assign out_last  = head.last;
  assign out_valid = (count_q != '0);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!syn_reset_n)
    push |-> (count_q < FCNT_W'(FIFO_DEPTH)));

endmodule
